// File: rtl/mips_multi_cycle_control.sv
// Moore-style control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and decodes ALU function.
module mips_multi_cycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       PCSrc,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MomtoReg,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t  state;
  state_t  state_next;

  alu_op_t alu_op;
  logic    valid;
  logic    pcwrite_fsm;
  logic    branch;
  logic    reg_dst;
  logic    alu_src_a;
  logic [1:0] alu_src_b;
  logic    pc_src;
  logic    mem_write;
  logic    i_or_d;
  logic    ir_write;
  logic    mom_to_reg;
  logic    reg_write;
  logic    illegal_op;
  logic [2:0] alu_ctl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    illegal_op = 1'b0;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          default: begin
            state_next = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR:  state_next = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_next = MEMWB;
      EXECUTE: state_next = ALUWB;
      ADDIEX:  state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  // valid stays 0 in unreachable encodings so even ALUControl is forced to 0 there
  always_comb begin
    valid       = 1'b1;
    alu_op      = ALUOP_ADD;
    pcwrite_fsm = 1'b0;
    branch      = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    mom_to_reg  = 1'b0;
    reg_write   = 1'b0;
    case (state)
      FETCH: begin
        ir_write    = 1'b1;
        alu_src_b   = 2'b01;
        pcwrite_fsm = 1'b1;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: i_or_d = 1'b1;
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      MEMWB: begin
        mom_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      ADDIWB: reg_write = 1'b1;
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        branch    = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctl = 3'b010;
    case (alu_op)
      ALUOP_SUB: alu_ctl = 3'b110;
      ALUOP_FUNCT: begin
        case (Funct)
          6'b100000: alu_ctl = 3'b010;
          6'b100010: alu_ctl = 3'b110;
          6'b100100: alu_ctl = 3'b000;
          6'b100101: alu_ctl = 3'b001;
          6'b101010: alu_ctl = 3'b111;
          default:   alu_ctl = 3'b010;
        endcase
      end
      default: alu_ctl = 3'b010;
    endcase
  end

  // Outputs are gated by reset so a mid-instruction assertion kills write strobes at once
  always_comb begin
    RegDst     = reset & reg_dst;
    ALUSrcA    = reset & alu_src_a;
    ALUSrcB    = reset ? alu_src_b : 2'b00;
    ALUControl = (reset && valid) ? alu_ctl : 3'b000;
    PCSrc      = reset & pc_src;
    PCWrite    = reset & (pcwrite_fsm | (branch & Zero));
    MemWrite   = reset & mem_write;
    IorD       = reset & i_or_d;
    IRWrite    = reset & ir_write;
    MomtoReg   = reset & mom_to_reg;
    RegWrite   = reset & reg_write;
    Illegal    = reset & illegal_op;
    State      = state;
  end

endmodule

// File: tb/tb_mips_multi_cycle_control.sv
// Bench for mips_multi_cycle_control: directed literal checks plus randomized
// instruction stream compared every cycle against a per-instruction sequence model.
module tb_mips_multi_cycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       RegDst, ALUSrcA, PCSrc, PCWrite, MemWrite, IorD, IRWrite;
  logic       MomtoReg, RegWrite, Illegal;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b1;
  int q[$];

  mips_multi_cycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .MomtoReg(MomtoReg), .RegWrite(RegWrite),
    .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] dut_vec;
  assign dut_vec = {RegDst, ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCWrite, MemWrite,
                    IorD, IRWrite, MomtoReg, RegWrite, Illegal, State};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
           op == 6'b000100 || op == 6'b001000;
  endfunction

  function automatic logic [2:0] fmap(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Whole-instruction state trace, chosen by opcode.
  task automatic push_seq(input logic [5:0] op);
    case (op)
      6'b100011: q = '{0, 1, 2, 3, 4};
      6'b101011: q = '{0, 1, 2, 5};
      6'b000000: q = '{0, 1, 6, 7};
      6'b000100: q = '{0, 1, 8};
      6'b001000: q = '{0, 1, 9, 10};
      default:   q = '{0, 1};
    endcase
  endtask

  function automatic logic [18:0] exp_vec(input int st, input logic [5:0] op,
                                          input logic [5:0] f, input logic z);
    logic rd, sa, pcs, pcw, mw, iod, irw, m2r, rw, ill;
    logic [1:0] sb;
    logic [2:0] alu;
    {rd, sa, pcs, pcw, mw, iod, irw, m2r, rw, ill} = '0;
    sb  = 2'b00;
    alu = 3'b010;
    case (st)
      0:  begin irw = 1; sb = 2'b01; pcw = 1; end
      1:  begin sb = 2'b11; ill = !is_legal(op); end
      2, 9: begin sa = 1; sb = 2'b10; end
      3:  iod = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin sa = 1; alu = fmap(f); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; alu = 3'b110; pcs = 1; pcw = z; end
      10: rw = 1;
      default: ;
    endcase
    return {rd, sa, sb, alu, pcs, pcw, mw, iod, irw, m2r, rw, ill, st[3:0]};
  endfunction

  always @(negedge clk) begin
    logic [18:0] e;
    int st;
    if (chk_en) begin
      cyc++;
      if (!reset) begin
        q.delete();
        e = '0;
      end else begin
        if (q.size() == 0) push_seq(Op);
        st = q.pop_front();
        e = exp_vec(st, Op, Funct, Zero);
      end
      check($sformatf("cyc%0d", cyc), {13'b0, dut_vec}, {13'b0, e});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] f);
    int n;
    Op = op;
    Funct = f;
    case (op)
      6'b100011: n = 5;
      6'b101011, 6'b000000, 6'b001000: n = 4;
      6'b000100: n = 3;
      default:   n = 2;
    endcase
    for (int i = 0; i < n; i++) begin
      Zero = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] ctls   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    int mw_cnt;
    int rw_cnt;
    logic [5:0] op;
    reset = 1'b0;
    Op = '0;
    Funct = '0;
    Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", State, 0);
    check("rst_pcwrite", PCWrite, 0);
    reset = 1'b1;

    // addi
    Op = 6'b001000;
    Funct = 6'h15;
    #1;
    check("fetch_state", State, 0);
    check("fetch_pcwrite", PCWrite, 1);
    check("fetch_irwrite", IRWrite, 1);
    check("fetch_srcb", ALUSrcB, 2'b01);
    check("fetch_aluctl", ALUControl, 3'b010);
    step(); check("addi_s1", State, 1);
    step(); check("addi_s9", State, 9);
    check("addiex_srca", ALUSrcA, 1);
    check("addiex_srcb", ALUSrcB, 2'b10);
    step(); check("addi_s10", State, 10);
    check("addiwb_rw", RegWrite, 1);
    check("addiwb_rd", RegDst, 0);
    step(); check("addi_end", State, 0);

    // R-type functions
    for (int i = 0; i < 5; i++) begin
      Op = 6'b000000;
      Funct = functs[i];
      step(); step();
      check($sformatf("rtype_state%0d", i), State, 6);
      check($sformatf("rtype_alu%0d", i), ALUControl, ctls[i]);
      step();
      check($sformatf("aluwb_rd%0d", i), RegDst, 1);
      check($sformatf("aluwb_rw%0d", i), RegWrite, 1);
      step();
      check($sformatf("rtype_end%0d", i), State, 0);
    end

    // lw
    Op = 6'b100011;
    step(); check("lw_s1", State, 1);
    step(); check("lw_s2", State, 2);
    step(); check("lw_s3", State, 3); check("memrd_iord", IorD, 1);
    step(); check("lw_s4", State, 4);
    check("memwb_m2r", MomtoReg, 1);
    check("memwb_rw", RegWrite, 1);
    step(); check("lw_end", State, 0);

    // sw: count strobes across the whole instruction
    Op = 6'b101011;
    mw_cnt = 0;
    rw_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      mw_cnt += int'(MemWrite);
      rw_cnt += int'(RegWrite);
      if (i == 3) check("sw_state", State, 5);
      @(posedge clk); #1;
    end
    check("sw_memwrite_cycles", mw_cnt, 1);
    check("sw_regwrite_cycles", rw_cnt, 0);

    // beq taken then not taken
    for (int t = 0; t < 2; t++) begin
      Op = 6'b000100;
      Zero = 1'b0;
      step(); step();
      check("beq_state", State, 8);
      Zero = (t == 0);
      #1;
      check($sformatf("beq%0d_pcwrite", t), PCWrite, (t == 0));
      check($sformatf("beq%0d_pcsrc", t), PCSrc, 1);
      check($sformatf("beq%0d_alu", t), ALUControl, 3'b110);
      step();
      check($sformatf("beq%0d_end", t), State, 0);
    end

    // illegal opcode
    Op = 6'b111111;
    step();
    check("ill_flag", Illegal, 1);
    check("ill_state", State, 1);
    check("ill_writes", {PCWrite, MemWrite, RegWrite, IRWrite}, 4'b0000);
    step();
    check("ill_end", State, 0);

    // randomized stream
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      if ($urandom_range(0, 4) == 0) run_instr(op, 6'($urandom_range(0, 63)));
      else run_instr(op, functs[$urandom_range(0, 4)]);
    end

    // reset asserted during MEMWR
    Op = 6'b101011;
    step(); step(); step();
    #1;
    check("memwr_before_rst", MemWrite, 1);
    reset = 1'b0;
    #1;
    check("memwr_after_rst", MemWrite, 0);
    check("state_after_rst", State, 0);
    check("pcw_after_rst", PCWrite, 0);
    step(); step();
    reset = 1'b1;
    #1;
    check("release_state", State, 0);
    check("release_pcwrite", PCWrite, 1);
    check("release_irwrite", IRWrite, 1);
    repeat (4) step();

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
